// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS
// common-anode digits. Each digit slot is a blanking gap (all anodes off,
// nibble already presented so the decoder settles) followed by a SHOW window.
// Loaded data is held in a shadow register and promoted to the active
// register only at frame boundaries, so a frame never mixes old and new data.
module display_scan_controller #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_COUNT = 27000,
  parameter int BLANK_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   enable_mask,
  output logic [3:0]              binary_code,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int MAXC  = (REFRESH_COUNT > BLANK_CYCLES) ? REFRESH_COUNT : BLANK_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [3:0]              binary_code_q, binary_code_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    frame_done_q, frame_done_d;
  logic                    boundary;

  // Next-state: slot sequencing, frame-boundary data promotion, and the
  // output values derived from the next state so outputs stay registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    boundary = 1'b0;
    shadow_d = load ? data_in : shadow_q;
    active_d = active_q;

    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_SHOW;
          cnt_d   = '0;
        end
      end
      S_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
      end
    endcase

    // A load coinciding with the boundary edge goes straight to the new frame.
    if (boundary) begin
      active_d = load ? data_in : shadow_q;
    end

    // Nibble is presented for the whole slot, including its blanking gap.
    binary_code_d = active_d[{idx_d, 2'b00} +: 4];

    // Only the digit in SHOW may light, and only if enabled.
    digit_sel_d = '1;
    if (state_d == S_SHOW) begin
      digit_sel_d[idx_d] = ~enable_mask[idx_d];
    end

    frame_done_d = boundary;
  end

  // State and registered outputs; reset clears everything including pending data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BLANK;
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      binary_code_q <= '0;
      digit_sel_q   <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      binary_code_q <= binary_code_d;
      digit_sel_q   <= digit_sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign binary_code = binary_code_q;
  assign digit_sel   = digit_sel_q;
  assign frame_done  = frame_done_q;

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexing scan controller for a multi-digit common-anode 7-segment display. It sequences one shared hex-to-segment decoder (4-bit `binary_code` in, 7-bit active-low `display_code` out) across `NUM_DIGITS` digits. It does this by cycling the active digit select and presenting that digit's nibble to the decoder. The block sits between the value producer (e.g. the Gray-to-binary decode path) and the display decoder/board pins, and it guarantees tear-free frames plus a blanking gap against ghosting.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of digits scanned; legal range 2..8.
- `REFRESH_COUNT`, default 27000: SHOW cycles per digit; must be ≥ 1.
- `BLANK_CYCLES`, default 16: all-off cycles before each digit's SHOW; must be ≥ 1.

Ports:
- `clk`, in, 1: single system clock; all logic rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `data_in`, in, 4*NUM_DIGITS: digit values; nibble i, bits [4i+3:4i], is digit i.
- `load`, in, 1: single-cycle strobe that captures `data_in` into the shadow register.
- `enable_mask`, in, NUM_DIGITS: per-digit enable; a 0 keeps that digit dark during its slot.
- `binary_code`, out, 4: nibble of the current digit, fed to the display decoder.
- `digit_sel`, out, NUM_DIGITS: active-low anode selects; `digit_sel[i]` = 0 lights digit i.
- `frame_done`, out, 1: one-cycle pulse at the start of every new frame.

## Operation
- Registers:
  - `shadow` and `active`, 4*NUM_DIGITS each.
  - `idx`, digit index.
  - `cnt`, width $clog2(max(REFRESH_COUNT, BLANK_CYCLES)).
  - `state` ∈ {BLANK, SHOW}.
- BLANK:
  - `digit_sel` is all ones.
  - `cnt` counts 0..BLANK_CYCLES-1.
  - At BLANK_CYCLES-1 → SHOW, `cnt` ← 0.
- SHOW:
  - `digit_sel[idx]` = ~`enable_mask[idx]`; all other bits are 1.
  - `cnt` counts 0..REFRESH_COUNT-1.
  - At REFRESH_COUNT-1 → BLANK, `cnt` ← 0, `idx` ← (idx+1) mod NUM_DIGITS.
- Frame boundary is the edge that ends the last SHOW cycle of digit NUM_DIGITS-1. On that edge:
  - `active` ← `load` ? `data_in` : `shadow`.
  - `frame_done` ← 1 for exactly one cycle, the first BLANK cycle of digit 0.
- `load`:
  - On any edge with `load`=1, `shadow` ← `data_in`.
  - `active` changes only at frame boundaries, so a frame never mixes old and new data.
  - Multiple loads within one frame: the last one wins.
- `binary_code` always equals `active[4*idx +: 4]` for the digit currently in BLANK or SHOW. It is stable across the whole slot, and is already valid during BLANK so the decoder settles before the anode turns on.
- A disabled digit still consumes its full slot, so scan timing is independent of `enable_mask`.

## Timing
- All outputs are registered. Reset values:
  - `digit_sel` = all ones.
  - `binary_code` = 0.
  - `frame_done` = 0.
  - `state`=BLANK, `idx`=0, `cnt`=0, `shadow`=`active`=0.
- First cycle after `rst` deassert is BLANK cycle 0 of digit 0. No `frame_done` is issued for this initial frame start.
- Slot length = BLANK_CYCLES + REFRESH_COUNT; frame length = NUM_DIGITS × slot.
- `frame_done` is high in cycle k × frame length after reset release, for k ≥ 1 (cycle 0 being the first post-reset cycle).
- `enable_mask` has one-cycle latency to `digit_sel` (registered), including mid-SHOW changes.
- `load` captured on edge t is visible on `binary_code` at the next frame boundary. If `load` is high during the last SHOW cycle of digit NUM_DIGITS-1, that data appears in the immediately following frame.
- `rst` asserted at any point, including mid-SHOW or on a boundary edge, forces all reset values on that edge. Pending `shadow` data is discarded, and the next frame starts from digit 0 BLANK.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_COUNT=5, BLANK_CYCLES=2 (slot 7, frame 28).

- **Reset values:** `rst`=1 for 3 cycles, `enable_mask`=4'b1111 → outputs 4'b1111/0/0. After release:
  - cycles 0-1: `digit_sel`=1111.
  - cycles 2-6: 1110.
  - cycles 9-13: 1101.
  - cycles 16-20: 1011.
  - cycles 23-27: 0111.
  - `frame_done`=1 only at cycle 28.
- **Load latency:** `load` with 16'h4321 at cycle 3 → `binary_code` stays 0 through cycle 27. From cycle 28: 1 (cycles 28-34), 2, 3, 4.
- **Mid-frame load:** `load` 16'hA5C3 at cycle 45, during digit 2 of frame 2 → digits 2/3 of frame 2 still show 3/4. Frame 3 shows 3, C, 5, A.
- **Boundary load, last-wins:** `load` 16'h1111 at cycle 30, then `load` 16'hFEDC at cycle 55 (last SHOW cycle of frame 2) → frame 3 (from cycle 56) shows C, D, E, F. 16'h1111 is never displayed.
- **Masked digits:** `enable_mask`=4'b0101 → digits 1 and 3 keep `digit_sel`=1111 throughout their slots. Digits 0 and 2 light normally. `frame_done` period remains 28.
- **Mid-operation reset:** `rst` for one cycle at cycle 20 (digit 2 SHOW) → cycle 21 shows all reset values, `active`=0. Digit 0 SHOW resumes at cycle 23, and the next `frame_done` is at cycle 49.
